// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// with a single full-subtractor cell and a registered borrow behind start/done.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             d_s;
  logic             br_next_s;
  logic [WIDTH-1:0] sr_shift_s;

  // Full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    d_s        = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next_s  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    sr_shift_s = {d_s, sr_q[WIDTH-1:1]};
  end

  // Next-state and output logic for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sa_d    = a_i;
          sb_d    = b_i;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d = {1'b0, sa_q[WIDTH-1:1]};
        sb_d = {1'b0, sb_q[WIDTH-1:1]};
        sr_d = sr_shift_s;
        br_d = br_next_s;
        // Counter is parked at zero on completion so it never reaches WIDTH.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          diff_d  = sr_shift_s;
          bout_d  = br_next_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 (directed + exhaustive)
// and WIDTH=8 (random), checked against plain-arithmetic expectations.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp4[$];
  logic [8:0] exp8[$];

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .diff_o(diff4), .bout_o(bout4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: {borrow, difference mod 2^W} from integer arithmetic.
  function automatic logic [4:0] model4(input int a, input int b);
    int d;
    d = (a - b + 16) % 16;
    return {(a < b) ? 1'b1 : 1'b0, d[3:0]};
  endfunction

  function automatic logic [8:0] model8(input int a, input int b);
    int d;
    d = (a - b + 256) % 256;
    return {(a < b) ? 1'b1 : 1'b0, d[7:0]};
  endfunction

  // Monitor for the WIDTH=4 instance.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n === 1'b1) begin
      check("overlap4", 32'(busy4 & done4), 32'd0);
      if (done4) begin
        if (exp4.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done4 actual=done diff=%0d required=no_done", diff4);
        end else begin
          e = exp4.pop_front();
          check("result4", 32'({bout4, diff4}), 32'(e));
        end
      end
    end
  end

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n === 1'b1) begin
      check("overlap8", 32'(busy8 & done8), 32'd0);
      if (done8) begin
        if (exp8.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done8 actual=done diff=%0d required=no_done", diff8);
        end else begin
          e = exp8.pop_front();
          check("result8", 32'({bout8, diff8}), 32'(e));
        end
      end
    end
  end

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic issue(input bit w8, input int a, input int b, input bit push);
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; a8 = 8'(a); b8 = 8'(b);
      if (push) exp8.push_back(model8(a, b));
    end else begin
      start4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
      if (push) exp4.push_back(model4(a, b));
    end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Counts edges from the accepting edge until done is seen (bounded).
  task automatic wait_done(input bit w8, output int n);
    n = 0;
    while (!(w8 ? done8 : done4) && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int nbusy;
    int ndone;
    rst_n  = 1'b0;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (5) begin
      @(negedge clk);
      check("reset4", 32'({busy4, done4, bout4, diff4}), 32'd0);
    end
    check("reset8", 32'({busy8, done8, bout8, diff8}), 32'd0);

    // No borrow: busy for 4 cycles, done after edge k+4, result held.
    issue(1'b0, 9, 5, 1'b1);
    nbusy = 0;
    n = 0;
    while (!done4 && n < 40) begin
      if (busy4) nbusy++;
      @(negedge clk);
      n++;
    end
    check("latency_nb", 32'(n), 32'd4);
    check("busy_cycles", 32'(nbusy), 32'd4);
    repeat (10) @(negedge clk);
    check("hold_diff", 32'({done4, bout4, diff4}), 32'd4);

    // Underflow, wrap and equal-operand corners.
    issue(1'b0, 3, 7, 1'b1);   wait_done(1'b0, n); check("lat_3_7", 32'(n), 32'd4);
    issue(1'b0, 0, 15, 1'b1);  wait_done(1'b0, n); check("lat_0_15", 32'(n), 32'd4);
    issue(1'b0, 15, 15, 1'b1); wait_done(1'b0, n); check("lat_15_15", 32'(n), 32'd4);
    issue(1'b0, 0, 0, 1'b1);   wait_done(1'b0, n); check("lat_0_0", 32'(n), 32'd4);

    // start while busy is ignored; start held in the done cycle is accepted.
    issue(1'b0, 9, 5, 1'b1);
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd2;
    n = 0;
    while (!done4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("lat_busy", 32'(n), 32'd4);
    a4 = 4'd6; b4 = 4'd1;
    exp4.push_back(model4(6, 1));
    @(negedge clk);
    start4 = 1'b0;
    wait_done(1'b0, n);
    check("b2b_gap", 32'(n + 1), 32'd5);

    // Reset after two RUN edges: outputs clear at once and no done follows.
    issue(1'b0, 9, 5, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_outputs", 32'({busy4, done4, bout4, diff4}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    issue(1'b0, 8, 3, 1'b1);
    wait_done(1'b0, n);
    check("lat_after_abort", 32'(n), 32'd4);

    // Exhaustive WIDTH=4 sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(1'b0, a, b, 1'b1);
        wait_done(1'b0, n);
        if (n != 4) check("lat_sweep4", 32'(n), 32'd4);
      end
    end

    // Randomized WIDTH=8 pairs, including the extremes.
    issue(1'b1, 0, 255, 1'b1); wait_done(1'b1, n); check("lat8_0_255", 32'(n), 32'd8);
    issue(1'b1, 255, 0, 1'b1); wait_done(1'b1, n); check("lat8_255_0", 32'(n), 32'd8);
    for (int i = 0; i < 200; i++) begin
      issue(1'b1, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), 1'b1);
      wait_done(1'b1, n);
      if (n != 8) check("lat_sweep8", 32'(n), 32'd8);
    end

    repeat (3) @(negedge clk);
    check("drain4", 32'(exp4.size()), 32'd0);
    check("drain8", 32'(exp8.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtraction counterpart to the team's parallel ripple adders, trading latency for area. It sits behind a simple start/done handshake so a controller can issue one operation at a time and read a held result.

## Interface
- `WIDTH`, default 4: operand and result width in bits. Legal values are WIDTH ≥ 2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation. Sampled only in IDLE.
- `a` in WIDTH: minuend, captured on the accepting edge.
- `b` in WIDTH: subtrahend, captured on the accepting edge.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse when `diff` and `bout` update.
- `diff` out WIDTH: `(a - b) mod 2^WIDTH`, held until the next completion.
- `bout` out 1: final borrow, which is 1 exactly when `a < b` (unsigned). Held with `diff`.

## Operation
- **State machine:** two states, IDLE and RUN.
- **IDLE:**
  - `start=1` at an edge captures `a` and `b` into internal shift registers `sa` and `sb`.
  - The same edge clears the internal borrow `br` and the bit counter `cnt`, sets `busy=1`, and moves to RUN.
  - `start=0` keeps the block in IDLE.
- **RUN:** each edge processes bit i = `cnt`:
  - `d = sa[0] ^ sb[0] ^ br`
  - `br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`
  - `d` shifts into the MSB of the internal result shift register `sr`.
  - `sa` and `sb` shift right by one.
  - `cnt` increments.
- **Completion:** at the edge where `cnt == WIDTH-1`:
  - `diff` is loaded with the fully shifted result (`{d, sr[WIDTH-1:1]}`).
  - `bout` is loaded with `br_next`.
  - `done` goes to 1, `busy` goes to 0, and the state returns to IDLE.
- **Outputs between operations:** `diff` and `bout` change only at completion. They are never visible mid-operation.
- **`start` while busy:** ignored, with no queuing. The `a`/`b` inputs are don't-care outside the accepting edge.
- **Back-to-back operations:** `start=1` during the cycle `done=1` (state is IDLE) is accepted. Back-to-back throughput is one result per WIDTH+1 cycles.
- **Counter width:** `cnt` is `$clog2(WIDTH)` bits and never exceeds WIDTH-1.
- **Reset (including mid-operation):** asserting `rst_n=0` immediately forces:
  - state IDLE
  - `busy=0`, `done=0`
  - `diff=0`, `bout=0`
  - `sa`, `sb`, `sr`, `br`, `cnt` all 0

  An aborted operation never produces `done`. After `rst_n` deasserts, the first `start` behaves normally.

## Timing
- **Reset values:** `busy=0`, `done=0`, `diff=0`, `bout=0`.
- **Latency:** `start` accepted at edge k gives `busy=1` after edge k. Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
- **Result timing:** `done=1`, `busy=0`, and new `diff`/`bout` appear after edge k+WIDTH. `done` drops after edge k+WIDTH+1 unless a new operation completes there, which is impossible since WIDTH ≥ 2.
- **Overlap:** `busy` and `done` are never high together.
- **Path:** no combinational path from inputs to outputs; all outputs are registered.

## Test plan
- **Reset values:** hold `rst_n=0`, then release; no `start` → `busy=0`, `done=0`, `diff=0`, `bout=0` indefinitely.
- **No borrow:** WIDTH=4, `a=9`, `b=5`, start pulse at edge k → `busy` high for 4 cycles; `done` pulses after edge k+4 with `diff=4`, `bout=0`. `diff` still reads 4 ten cycles later.
- **Underflow and wrap:**
  - `a=3`, `b=7` → `diff=12`, `bout=1`.
  - `a=0`, `b=15` → `diff=1`, `bout=1`.
  - `a=15`, `b=15` → `diff=0`, `bout=0`.
  - `a=0`, `b=0` → `diff=0`, `bout=0`.
- **Busy and back-to-back:**
  - Start `a=9`, `b=5`. While busy, drive `start=1` with `a=1`, `b=2` → ignored; result is `diff=4`.
  - Then hold `start=1` with `a=6`, `b=1` during the `done` cycle → accepted; second `done` arrives 5 cycles after the first with `diff=5`, `bout=0`.
- **Reset mid-operation:** start `a=9`, `b=5`, assert `rst_n=0` after 2 RUN edges → outputs are immediately 0 and no `done` follows. Then start `a=8`, `b=3` → `diff=5`, `bout=0` with normal latency.
- **Exhaustive sweep:** all 256 `a`/`b` pairs at WIDTH=4 → `diff == (a-b)&15` and `bout == (a<b)` for every pair. Repeat with randomized pairs at WIDTH=8.
